// File: rtl/mem_timer_pkg.sv
// -----------------------------------------------------------------------------
// mem_timer_pkg
// Shared definitions for the memory-mapped timer:
//   - register offsets (byte offsets from BASE)
//   - CTL bit positions
//   - counting mode encoding
//   - byte_merge(): byte-lane write merge used by every writable register
// -----------------------------------------------------------------------------
package mem_timer_pkg;

  // Byte offsets of the registers relative to BASE.
  localparam logic [2:0] OFF_CTL  = 3'd0;
  localparam logic [2:0] OFF_TAR  = 3'd2;
  localparam logic [2:0] OFF_CCR0 = 3'd4;

  // CTL bit positions.
  localparam int CTL_EN     = 0;
  localparam int CTL_MODE   = 1;
  localparam int CTL_IE     = 2;
  localparam int CTL_IFG    = 3;
  localparam int CTL_ID_LSB = 4;
  localparam int CTL_ID_MSB = 5;
  localparam int CTL_CLR    = 8;

  // Counting mode held in CTL.MODE.
  typedef enum logic {
    MODE_CONT = 1'b0,  // free-running 0..FFFF
    MODE_UP   = 1'b1   // 0..CCR0
  } mode_e;

  // Merge a CPU write into an existing 16-bit register.
  //   word write        : all 16 bits replaced
  //   byte write, hi=0  : wdata[7:0] -> reg[7:0]
  //   byte write, hi=1  : wdata[7:0] -> reg[15:8]
  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] wdata,
                                             input logic        bw,
                                             input logic        hi);
    logic [15:0] res;
    res = old_val;
    if (!bw) begin
      res = wdata;
    end else if (hi) begin
      res[15:8] = wdata[7:0];
    end else begin
      res[7:0] = wdata[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_timer_if.sv
// -----------------------------------------------------------------------------
// mem_timer_if
// CPU memory bus as seen by a peripheral responder.
//   MAB_in     : address (initiator -> responder)
//   MDB_in     : write data (initiator -> responder)
//   MW         : write strobe, 1 = write this cycle
//   BW         : 1 = byte access, 0 = word access
//   periph_MDB : read data, combinational from MAB_in/BW (responder -> initiator)
//   periph_hit : address decodes to the responder (responder -> initiator)
// Bus timing: there is no valid/ready handshake. A write is accepted on the
// rising clock edge at which MW=1 and periph_hit=1; a read is valid in the
// same cycle the address is presented, with zero wait states.
// -----------------------------------------------------------------------------
interface mem_timer_if;
  logic [15:0] MAB_in;
  logic [15:0] MDB_in;
  logic        MW;
  logic        BW;
  logic [15:0] periph_MDB;
  logic        periph_hit;

  modport master (
    output MAB_in, MDB_in, MW, BW,
    input  periph_MDB, periph_hit
  );

  modport slave (
    input  MAB_in, MDB_in, MW, BW,
    output periph_MDB, periph_hit
  );
endinterface

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock by 1/2/4/8 and emits a one-cycle tick.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   en   in   count enable; count is held at 0 while low
//   clr  in   synchronous clear of the count
//   id   in   divider select: 0=/1, 1=/2, 2=/4, 3=/8
//   tick out  1 when the count reaches divisor-1 while enabled
// -----------------------------------------------------------------------------
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] id,
  output logic       tick
);

  logic [2:0] r_cnt;
  logic [2:0] w_lim;

  always_comb begin
    w_lim = 3'd0;
    case (id)
      2'd0:    w_lim = 3'd0;
      2'd1:    w_lim = 3'd1;
      2'd2:    w_lim = 3'd3;
      default: w_lim = 3'd7;
    endcase
  end

  // The tick reflects the count as it stands; the owner decides whether a
  // simultaneous clear also cancels this cycle's tick.
  assign tick = en && (r_cnt == w_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (!en || clr || tick) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/mem_timer.sv
// -----------------------------------------------------------------------------
// mem_timer
// Memory-mapped 16-bit timer responding on the CPU memory bus.
//   BASE+0 CTL  : [0]EN [1]MODE [2]IE [3]IFG [5:4]ID [8]CLR(write-only)
//   BASE+2 TAR  : counter
//   BASE+4 CCR0 : compare value for up mode
//   BASE+6/7    : not decoded
// Ports:
//   clk  in    system clock
//   rst  in    asynchronous active-low reset
//   bus  slave CPU bus (address, write data, strobes, read data, hit)
//   irq  out   interrupt request = CTL.IE & CTL.IFG
// -----------------------------------------------------------------------------
module mem_timer
  import mem_timer_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0160,
  parameter int          SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_timer_if.slave  bus,
  output logic        irq
);

  // Register state
  logic [SIZE-1:0] r_tar;
  logic [SIZE-1:0] r_ccr0;
  logic            r_en;
  mode_e           r_mode;
  logic            r_ie;
  logic            r_ifg;
  logic [1:0]      r_id;

  // Decode
  logic [2:0]  w_off;
  logic        w_hi;
  logic        w_hit;
  logic        w_wr;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_wr_ctl;
  logic        w_wr_tar;
  logic        w_wr_ccr0;
  logic        w_ctl_lo_wr;
  logic        w_clr;
  logic        w_psc_clr;
  logic        w_tick;
  logic        w_tick_eff;
  logic        w_wrap;
  logic        w_hw_ifg;
  logic [15:0] w_ctl_rd;
  logic [15:0] w_sel;

  assign w_off = {bus.MAB_in[2:1], 1'b0};
  assign w_hi  = bus.MAB_in[0];
  assign w_hit = (bus.MAB_in[15:3] == BASE[15:3]) && (bus.MAB_in[2:1] != 2'b11);

  // Byte lanes touched by this access; a word access ignores MAB_in[0].
  assign w_wr      = bus.MW && w_hit;
  assign w_wr_lo   = !bus.BW || !w_hi;
  assign w_wr_hi   = !bus.BW || w_hi;
  assign w_wr_ctl  = w_wr && (w_off == OFF_CTL);
  assign w_wr_tar  = w_wr && (w_off == OFF_TAR);
  assign w_wr_ccr0 = w_wr && (w_off == OFF_CCR0);

  // CTL low byte holds every stored control bit, including ID.
  assign w_ctl_lo_wr = w_wr_ctl && w_wr_lo;

  // CLR lives in the high byte: bit 8 of a word write, bit 0 of a high-byte write.
  assign w_clr = w_wr_ctl && w_wr_hi &&
                 (bus.BW ? bus.MDB_in[0] : bus.MDB_in[CTL_CLR]);

  // Any CLR or ID write restarts the prescaler phase.
  assign w_psc_clr = w_clr || w_ctl_lo_wr;

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (r_en),
    .clr  (w_psc_clr),
    .id   (r_id),
    .tick (w_tick)
  );

  // A CLR write suppresses counting for its cycle; an ID-only write does not.
  assign w_tick_eff = w_tick && !w_clr;

  // FFFF always wraps, which also covers up mode after CCR0 was lowered below
  // TAR: the count runs on to FFFF, wraps, and compares normally afterwards.
  assign w_wrap   = (r_tar == 16'hFFFF) || ((r_mode == MODE_UP) && (r_tar == r_ccr0));
  assign w_hw_ifg = w_tick_eff && w_wrap;

  always_comb begin
    w_ctl_rd                        = 16'h0000;
    w_ctl_rd[CTL_EN]                = r_en;
    w_ctl_rd[CTL_MODE]              = r_mode;
    w_ctl_rd[CTL_IE]                = r_ie;
    w_ctl_rd[CTL_IFG]               = r_ifg;
    w_ctl_rd[CTL_ID_MSB:CTL_ID_LSB] = r_id;
  end

  always_comb begin
    w_sel = 16'h0000;
    case (w_off)
      OFF_CTL:  w_sel = w_ctl_rd;
      OFF_TAR:  w_sel = r_tar;
      OFF_CCR0: w_sel = r_ccr0;
      default:  w_sel = 16'h0000;
    endcase
  end

  always_comb begin
    bus.periph_MDB = 16'h0000;
    if (w_hit) begin
      if (!bus.BW)   bus.periph_MDB = w_sel;
      else if (w_hi) bus.periph_MDB = {8'h00, w_sel[15:8]};
      else           bus.periph_MDB = {8'h00, w_sel[7:0]};
    end
  end

  assign bus.periph_hit = w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tar  <= '0;
      r_ccr0 <= '0;
      r_en   <= 1'b0;
      r_mode <= MODE_CONT;
      r_ie   <= 1'b0;
      r_ifg  <= 1'b0;
      r_id   <= 2'd0;
    end else begin
      if (w_ctl_lo_wr) begin
        r_en   <= bus.MDB_in[CTL_EN];
        r_mode <= mode_e'(bus.MDB_in[CTL_MODE]);
        r_ie   <= bus.MDB_in[CTL_IE];
        r_id   <= bus.MDB_in[CTL_ID_MSB:CTL_ID_LSB];
      end

      // Hardware set wins over a software clear in the same cycle.
      if (w_ctl_lo_wr) begin
        r_ifg <= bus.MDB_in[CTL_IFG] || w_hw_ifg;
      end else if (w_hw_ifg) begin
        r_ifg <= 1'b1;
      end

      // CLR first, then CPU write, then counting.
      if (w_clr) begin
        r_tar <= '0;
      end else if (w_wr_tar) begin
        r_tar <= byte_merge(r_tar, bus.MDB_in, bus.BW, w_hi);
      end else if (w_tick_eff) begin
        r_tar <= w_wrap ? 16'h0000 : (r_tar + 16'd1);
      end

      if (w_wr_ccr0) begin
        r_ccr0 <= byte_merge(r_ccr0, bus.MDB_in, bus.BW, w_hi);
      end
    end
  end

  assign irq = r_ie && r_ifg;

endmodule

// File: doc/mem_timer.md
Name: mem_timer

Overview:
- Memory-mapped 16-bit timer that responds to CPU accesses on the MAB/MDB memory bus.
- The CPU is the bus initiator (address MAB_in, write data MDB_in, strobes MW/BW); this block is a responder beside mem_space.
- Read data goes out on periph_MDB together with periph_hit; the top-level MDB_out mux selects it on a hit.
- Provides continuous/up counting, a prescaler, a compare register and an interrupt request.

Parameters:
- BASE, 16'h0160, word-aligned base address; bits [2:0] of BASE must be 0.
- SIZE, 16, data width; fixed at 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- MAB_in  in  16  memory address bus from CPU.
- MDB_in  in  16  write data from CPU.
- MW  in  1  write strobe; 1 = write this cycle.
- BW  in  1  byte access; 1 = byte, 0 = word.
- periph_MDB  out  16  read data (combinational).
- periph_hit  out  1  address decodes to this block (combinational).
- irq  out  1  interrupt request, equal to CTL.IE & CTL.IFG.

Behaviour:
- Address map (offset = MAB_in - BASE):
  - 0: CTL
  - 2: TAR
  - 4: CCR0
  - periph_hit = 1 when MAB_in[15:3] == BASE[15:3] and MAB_in[2:1] != 2'b11. Offsets 6–7 are not decoded.
- CTL bits:
  - [0] EN
  - [1] MODE (0 = continuous, 1 = up to CCR0)
  - [2] IE
  - [3] IFG
  - [5:4] ID: divide by 1/2/4/8
  - [8] CLR, write-only, self-clearing, reads 0
  - all other bits read 0
- Reset (rst low, asynchronous): CTL, TAR, CCR0 and the prescaler count all = 0; irq = 0. periph_MDB and periph_hit follow the combinational decode.
- Writes take effect at posedge clk when MW & periph_hit:
  - Word write (BW=0): MAB_in[0] is ignored; all 16 bits are written.
  - Byte write (BW=1), MAB_in[0]=0: MDB_in[7:0] goes to reg[7:0]; upper byte unchanged.
  - Byte write (BW=1), MAB_in[0]=1: MDB_in[7:0] goes to reg[15:8]; lower byte unchanged.
- Reads are combinational, zero latency:
  - Word read: periph_MDB = selected register.
  - Byte read: the selected byte is zero-extended into [7:0].
  - No hit: periph_MDB = 0.
- Prescaler:
  - 3-bit counter; advances only while EN=1.
  - tick = 1 when the count equals the divisor minus 1; the count then wraps to 0.
  - Count clears when EN=0, on a CLR write, or on any write to CTL.ID.
- Counter, evaluated on a tick:
  - Continuous mode: TAR == 16'hFFFF gives TAR → 0 and IFG ← 1; otherwise TAR + 1.
  - Up mode: TAR == CCR0 gives TAR → 0 and IFG ← 1; otherwise TAR + 1.
  - Up mode, TAR > CCR0 (CCR0 lowered while running): count continues up to 16'hFFFF, wraps to 0 and sets IFG, then resumes up-mode compare.
  - CCR0 = 0 in up mode: TAR held at 0, IFG set on every tick.
- Priority within a single cycle:
  - CLR write: TAR ← 0, prescaler ← 0, and no tick this cycle.
  - A CPU TAR write overrides the tick increment in the same cycle.
  - A hardware IFG set overrides a software write of IFG=0 in the same cycle.
  - A software write of IFG=1 sets IFG.
- irq is registered-consistent: it updates in the same cycle as IFG/IE change. There is no auto-clear on read.
- EN=0 freezes TAR. Register writes remain allowed while stopped.

Decomposition:
- Package mem_timer_pkg:
  - offset constants OFF_CTL / OFF_TAR / OFF_CCR0
  - CTL bit indices CTL_EN, CTL_MODE, CTL_IE, CTL_IFG, CTL_ID_LSB/MSB, CTL_CLR
  - mode encodings MODE_CONT / MODE_UP
- Sub-module timer_prescaler:
  - inputs: clk, rst, en, clr, id[1:0]
  - output: tick
- Byte-lane merge function: shared in the package.

Test Plan:
- Reset: rst low mid-count → TAR=0, CTL=0, CCR0=0, irq=0 immediately, without a clock edge; read BASE+2 → periph_MDB=0, periph_hit=1.
- Up mode: CCR0=4, CTL=0x0007 (EN, MODE=up, IE) → TAR sequence 0,1,2,3,4,0; IFG=1 and irq=1 on the cycle after TAR=4.
- Prescale: CTL=0x0021 (EN, ID=/4, continuous) → TAR increments every 4 clk; after 40 clk TAR=10.
- Continuous wrap: write TAR=16'hFFFE, CTL=0x0001 → TAR goes to FFFF then 0; IFG=1; irq stays 0 because IE=0.
- Byte access: word-write CCR0=0x1234; byte-write 0xAB at BASE+5 → CCR0=0xAB34; byte read at BASE+4 → periph_MDB=0x0034.
- Collisions:
  - TAR write of 0x0100 on a tick cycle → TAR=0x0100.
  - Software IFG=0 write coincident with an up-mode match → IFG=1.
  - CLR write → TAR=0, CTL[8] reads 0.
